// File: rtl/mips_pkg.sv
// Shared MIPS32 decode constants: ALU operator codes, ALUOP encodings and R-type funct values.
package mips_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ORI   = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: maps aluop/funct to the 4-bit ALU operator and flags unknown funct codes.
module alu_control
    import mips_pkg::*;
(
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    output logic [ALU_W-1:0] operador,
    output logic             illegal
);

    always_comb begin
        operador = ALU_ADD;
        illegal  = 1'b0;
        case (aluop_e'(aluop))
            ALUOP_ADD: operador = ALU_ADD;
            ALUOP_SUB: operador = ALU_SUB;
            ALUOP_ORI: operador = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: operador = ALU_ADD;
                    FUNCT_SUB: operador = ALU_SUB;
                    FUNCT_AND: operador = ALU_AND;
                    FUNCT_OR:  operador = ALU_OR;
                    FUNCT_SLT: operador = ALU_SLT;
                    FUNCT_NOR: operador = ALU_NOR;
                    default: begin
                        operador = ALU_ADD;
                        illegal  = 1'b1;
                    end
                endcase
            end
            default: operador = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register producing registered ALU operands and operator.
// Optional EX/MEM bypass into the operands when FORWARDING_EN is defined.
module id_ex_alu_stage
    import mips_pkg::*;
#(
    parameter int SIZEDATA = 32,
    parameter int OP       = 4,
    parameter int REGADDR  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZEDATA-1:0] in_rs_data,
    input  logic [SIZEDATA-1:0] in_rt_data,
    input  logic [15:0]         in_imm,
    input  logic                in_alu_src,
    input  logic [1:0]          in_aluop,
    input  logic [5:0]          in_funct,
    input  logic [REGADDR-1:0]  in_rd,
    input  logic                in_reg_write,
`ifdef FORWARDING_EN
    input  logic [REGADDR-1:0]  in_rs,
    input  logic [REGADDR-1:0]  in_rt,
    input  logic                fwd_valid,
    input  logic [REGADDR-1:0]  fwd_rd,
    input  logic [SIZEDATA-1:0] fwd_data,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZEDATA-1:0] a,
    output logic [SIZEDATA-1:0] b,
    output logic [OP-1:0]       operador,
    output logic [REGADDR-1:0]  out_rd,
    output logic                out_reg_write,
    output logic                illegal,
    output logic [15:0]         stall_cnt
);

    logic                load;
    logic [SIZEDATA-1:0] rs_op;
    logic [SIZEDATA-1:0] rt_op;
    logic [SIZEDATA-1:0] ext_imm;
    logic [ALU_W-1:0]    dec_op;
    logic                dec_illegal;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign load     = in_valid && in_ready;

`ifdef FORWARDING_EN
    // $0 is hardwired to zero, so a pending write to it must never be bypassed.
    assign rs_op = (fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rs)) ? fwd_data : in_rs_data;
    assign rt_op = (fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rt)) ? fwd_data : in_rt_data;
`else
    assign rs_op = in_rs_data;
    assign rt_op = in_rt_data;
`endif

    assign ext_imm = (aluop_e'(in_aluop) == ALUOP_ORI) ? {{(SIZEDATA-16){1'b0}}, in_imm}
                                                       : {{(SIZEDATA-16){in_imm[15]}}, in_imm};

    alu_control u_alu_control (
        .aluop    (in_aluop),
        .funct    (in_funct),
        .operador (dec_op),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            a             <= '0;
            b             <= '0;
            operador      <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            illegal       <= 1'b0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            a             <= rs_op;
            b             <= in_alu_src ? ext_imm : rt_op;
            operador      <= OP'(dec_op);
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
            illegal       <= dec_illegal;
        end else if (out_valid && out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Self-checking bench for id_ex_alu_stage: per-cycle model comparison plus directed literal checks.
// Forwarding vectors are exercised when FORWARDING_EN is defined.
module tb_id_ex_alu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic [15:0] in_imm;
    logic        in_alu_src;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic [4:0]  in_rd;
    logic        in_reg_write;
`ifdef FORWARDING_EN
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  operador;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        illegal;
    logic [15:0] stall_cnt;

    int nchecks = 0;
    int nerrors = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    id_ex_alu_stage #(.SIZEDATA(32), .OP(4), .REGADDR(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs_data    (in_rs_data),
        .in_rt_data    (in_rt_data),
        .in_imm        (in_imm),
        .in_alu_src    (in_alu_src),
        .in_aluop      (in_aluop),
        .in_funct      (in_funct),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
`ifdef FORWARDING_EN
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .a             (a),
        .b             (b),
        .operador      (operador),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .illegal       (illegal),
        .stall_cnt     (stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the operator table.
    function automatic logic [4:0] ref_decode(input logic [1:0] aluop, input logic [5:0] funct);
        case (aluop)
            2'b00: return {1'b0, 4'b0010};
            2'b01: return {1'b0, 4'b0110};
            2'b11: return {1'b0, 4'b0001};
            default: begin
                case (funct)
                    6'b100000: return {1'b0, 4'b0010};
                    6'b100010: return {1'b0, 4'b0110};
                    6'b100100: return {1'b0, 4'b0000};
                    6'b100101: return {1'b0, 4'b0001};
                    6'b101010: return {1'b0, 4'b0111};
                    6'b100111: return {1'b0, 4'b1100};
                    default:   return {1'b1, 4'b0010};
                endcase
            end
        endcase
    endfunction

    bit          m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    bit          m_rw, m_ill;
    int          m_stall;

    always @(posedge clk) begin
        logic [31:0] rsv, rtv, immv;
        logic [4:0]  d;
        bit          accept, was_valid;
        accept    = in_valid && !flush && (!m_valid || out_ready);
        was_valid = m_valid;
        if (rst) begin
            m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_rw = 0; m_ill = 0; m_stall = 0;
        end else begin
            if (was_valid && !out_ready && m_stall < 65535) m_stall = m_stall + 1;
            if (flush) begin
                m_valid = 0;
                m_rw    = 0;
            end else if (accept) begin
                rsv = in_rs_data;
                rtv = in_rt_data;
`ifdef FORWARDING_EN
                if (fwd_valid && fwd_rd != 0 && fwd_rd == in_rs) rsv = fwd_data;
                if (fwd_valid && fwd_rd != 0 && fwd_rd == in_rt) rtv = fwd_data;
`endif
                if (in_aluop == 2'b11) immv = {16'h0000, in_imm};
                else immv = {{16{in_imm[15]}}, in_imm};
                d       = ref_decode(in_aluop, in_funct);
                m_valid = 1;
                m_a     = rsv;
                m_b     = in_alu_src ? immv : rtv;
                m_op    = d[3:0];
                m_ill   = d[4];
                m_rd    = in_rd;
                m_rw    = in_reg_write;
            end else if (was_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            check("a", a, m_a);
            check("b", b, m_b);
            check("operador", {28'b0, operador}, {28'b0, m_op});
            check("out_rd", {27'b0, out_rd}, {27'b0, m_rd});
            check("out_reg_write", {31'b0, out_reg_write}, {31'b0, m_rw});
            check("illegal", {31'b0, illegal}, {31'b0, m_ill});
            check("stall_cnt", {16'b0, stall_cnt}, m_stall);
            check("in_ready", {31'b0, in_ready}, {31'b0, (!flush && (!m_valid || out_ready))});
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                         input logic src, input logic [4:0] rd, input logic rw);
        in_valid     = v;
        in_aluop     = op;
        in_funct     = fn;
        in_rs_data   = rsd;
        in_rt_data   = rtd;
        in_imm       = imm;
        in_alu_src   = src;
        in_rd        = rd;
        in_reg_write = rw;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(0, 2'b00, 6'h00, 0, 0, 0, 0, 0, 0);
`ifdef FORWARDING_EN
        in_rs = 0; in_rt = 0; fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
`endif
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset a", a, 32'd0);
        check("reset operador", {28'b0, operador}, 32'd0);
        check("reset stall_cnt", {16'b0, stall_cnt}, 32'd0);

        // R-type sub
        drive(1, 2'b10, 6'b100010, 32'd7, 32'd3, 16'h0000, 0, 5'd5, 1);
        step();
        check("sub out_valid", {31'b0, out_valid}, 32'd1);
        check("sub a", a, 32'd7);
        check("sub b", b, 32'd3);
        check("sub operador", {28'b0, operador}, 32'h6);
        check("sub illegal", {31'b0, illegal}, 32'd0);
        idle();

        // Sign-extended and zero-extended immediates
        drive(1, 2'b00, 6'h00, 32'd1, 32'd2, 16'hFFFC, 1, 5'd6, 1);
        step();
        check("addi b", b, 32'hFFFFFFFC);
        check("addi operador", {28'b0, operador}, 32'h2);
        drive(1, 2'b11, 6'h00, 32'd1, 32'd2, 16'hFFFC, 1, 5'd7, 1);
        step();
        check("ori b", b, 32'h0000FFFC);
        check("ori operador", {28'b0, operador}, 32'h1);
        idle();

        // Back-pressure for 5 cycles, then consume + load with no bubble
        out_ready = 1'b0;
        drive(1, 2'b10, 6'b100100, 32'hA5A5_0001, 32'h0F0F_0F0F, 0, 0, 5'd8, 1);
        step();
        check("stall in_ready", {31'b0, in_ready}, 32'd0);
        drive(1, 2'b10, 6'b100101, 32'h1234_5678, 32'h0000_00FF, 0, 0, 5'd9, 1);
        repeat (5) step();
        check("stall held a", a, 32'hA5A5_0001);
        check("stall_cnt 5", {16'b0, stall_cnt}, 32'd5);
        out_ready = 1'b1;
        step();
        check("no bubble out_valid", {31'b0, out_valid}, 32'd1);
        check("no bubble a", a, 32'h1234_5678);
        check("no bubble operador", {28'b0, operador}, 32'h1);
        idle();
        idle();

        // Flush with valid contents and a presented instruction
        drive(1, 2'b10, 6'b101010, 32'd11, 32'd22, 0, 0, 5'd10, 1);
        step();
        flush = 1'b1;
        drive(1, 2'b10, 6'b100111, 32'd33, 32'd44, 0, 0, 5'd11, 1);
        #1;
        check("flush in_ready", {31'b0, in_ready}, 32'd0);
        step();
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        check("flush out_reg_write", {31'b0, out_reg_write}, 32'd0);
        check("flush not captured a", a, 32'd11);
        flush = 1'b0;
        idle();

        // Unknown funct, then a legal instruction clears illegal
        drive(1, 2'b10, 6'b001000, 32'd5, 32'd6, 0, 0, 5'd12, 1);
        step();
        check("jr operador", {28'b0, operador}, 32'h2);
        check("jr illegal", {31'b0, illegal}, 32'd1);
        drive(1, 2'b10, 6'b100000, 32'd5, 32'd6, 0, 0, 5'd13, 0);
        step();
        check("legal clears illegal", {31'b0, illegal}, 32'd0);

        // Back-to-back stream across every funct, consumed every cycle
        for (int unsigned i = 0; i < 8; i++) begin
            logic [5:0] fl [8];
            fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h3F, 6'h20};
            drive(1, 2'b10, fl[i], 32'h100 + i, 32'h200 + i, 16'h8000, (i == 7), 5'(i), i[0]);
            step();
        end
        idle();

        // Intermittent back-pressure mixed with loads
        for (int unsigned i = 0; i < 6; i++) begin
            out_ready = i[0];
            drive(1, 2'(i), 6'h22, 32'h5000 + i, 32'h6000 + i, 16'h7FF0 + 16'(i), i[1], 5'(i + 20), 1);
            step();
        end
        out_ready = 1'b1;
        idle();

`ifdef FORWARDING_EN
        fwd_valid = 1; fwd_rd = 5'd9; fwd_data = 32'h0000DEAD; in_rs = 5'd9; in_rt = 5'd4;
        drive(1, 2'b00, 6'h00, 32'h1111, 32'h2222, 0, 0, 5'd1, 1);
        step();
        check("fwd rs a", a, 32'h0000DEAD);
        check("fwd rs b unaffected", b, 32'h2222);
        fwd_rd = 5'd0; in_rs = 5'd0; in_rt = 5'd0;
        drive(1, 2'b00, 6'h00, 32'h3333, 32'h4444, 0, 0, 5'd1, 1);
        step();
        check("fwd r0 a", a, 32'h3333);
        fwd_rd = 5'd4; in_rs = 5'd3; in_rt = 5'd4;
        drive(1, 2'b00, 6'h00, 32'h5555, 32'h6666, 0, 0, 5'd1, 1);
        step();
        check("fwd rt b", b, 32'h0000DEAD);
        drive(1, 2'b00, 6'h00, 32'h5555, 32'h6666, 16'h0010, 1, 5'd1, 1);
        step();
        check("fwd imm path", b, 32'h00000010);
        fwd_valid = 0;
        idle();
`endif

        // Reset mid-operation overrides flush and load
        out_ready = 1'b0;
        drive(1, 2'b01, 6'h00, 32'd99, 32'd98, 0, 0, 5'd3, 1);
        step();
        step();
        rst = 1'b1; flush = 1'b1;
        step();
        check("midrst out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst a", a, 32'd0);
        check("midrst stall_cnt", {16'b0, stall_cnt}, 32'd0);
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
